// File: rtl/acc_pkg.sv
// Shared types and constants for the frame accumulator.
package acc_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_COUNT = 4;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

  // Smallest n with 2**n >= value; evaluated at elaboration for HW.
  function automatic int acc_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_accumulator_if.sv
// Operand stream and total stream of the frame accumulator.
// Optional feature macro: ACC_SAT_EN adds the out_ovf signal.
interface seq_accumulator_if
  import acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HW    = acc_clog2(DEF_COUNT)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [HW-1:0]    out_hi;
`ifdef ACC_SAT_EN
  logic             out_ovf;
`endif

`ifdef ACC_SAT_EN
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_hi, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_hi, out_ovf
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_hi
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_hi
  );
`endif

endinterface

// File: rtl/carryadder.sv
// Ripple-carry adder; cout exposes the carry out of every bit position.
module carryadder #(
  parameter int size = 4
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            cin,
  output logic [size-1:0] sum,
  output logic [size-1:0] cout
);

  always_comb begin
    logic c;
    c    = cin;
    sum  = '0;
    cout = '0;
    for (int i = 0; i < size; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c;
      c       = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      cout[i] = c;
    end
  end

endmodule

// File: rtl/seq_accumulator.sv
// Sums COUNT operands per frame, extending precision by counting carry-outs.
// Optional feature macro: ACC_SAT_EN (sticky saturation instead of carry counting).
module seq_accumulator
  import acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT
) (
  input logic             clk,
  input logic             rst,
  input logic             clear,
  seq_accumulator_if.slave bus
);

  localparam int HW = acc_clog2(COUNT);
  localparam logic [HW-1:0] CNT_LAST = HW'(COUNT - 1);

  acc_state_t       state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [HW-1:0]    hi_reg, hi_next;
  logic [HW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] add_cout;
  logic             carry;
  logic             in_ready;
  logic             out_valid;
`ifdef ACC_SAT_EN
  logic             ovf_reg, ovf_next;
`endif

  carryadder #(
    .size (WIDTH)
  ) u_adder (
    .a    (acc_reg),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign carry = add_cout[WIDTH-1];

  // Only the final carry matters; the inner ripple carries are intentionally dropped.
  logic unused_carries;
  assign unused_carries = ^add_cout[WIDTH-2:0];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
`ifdef ACC_SAT_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      hi_reg    <= hi_next;
      cnt_reg   <= cnt_next;
`ifdef ACC_SAT_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    hi_next    = hi_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef ACC_SAT_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      ACC: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_next = add_sum;
          hi_next  = hi_reg + HW'(carry);
          cnt_next = cnt_reg + HW'(1);
`ifdef ACC_SAT_EN
          // Once any carry is seen the frame total pins at all-ones.
          if (carry || ovf_reg) begin
            ovf_next = 1'b1;
            acc_next = '1;
            hi_next  = '0;
          end
`endif
          if (cnt_reg == CNT_LAST) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = ACC;
          acc_next   = '0;
          hi_next    = '0;
          cnt_next   = '0;
`ifdef ACC_SAT_EN
          ovf_next   = 1'b0;
`endif
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc_reg;
  assign bus.out_hi    = hi_reg;
`ifdef ACC_SAT_EN
  assign bus.out_ovf   = ovf_reg;
`endif

endmodule

// File: doc/seq_accumulator.md
# seq_accumulator

Frame accumulator that sits directly downstream of the ripple-carry adder datapath. It sums COUNT consecutive WIDTH-bit operands accepted over a valid/ready stream, using one `carryadder` instance and a registered running total. It counts adder carry-outs to extend precision, then presents the frame total on a valid/ready output port until the consumer takes it.

## Interface
- WIDTH, 4, operand and partial-sum width; it is also the adder `size`.
- COUNT, 4, operands per frame; legal range is 2 or more.
- HW, $clog2(COUNT), derived localparam; width of the carry counter.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous frame abort; same effect as rst on block state.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  operand.
- out_valid  out  1  frame total available.
- out_ready  in  1  consumer takes the total.
- out_sum  out  WIDTH  low part of the total.
- out_hi  out  HW  number of carry-outs in the frame, i.e. the high part of the total.
- out_ovf  out  1  saturation flag; present only with ACC_SAT_EN.

## Operation
- Adder connection:
  - a = acc, b = in_data, cin = 0.
  - The carry is the adder's cout[WIDTH-1].
- States: ACC and HOLD.
- ACC state:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: acc <= sum, hi <= hi + carry, cnt <= cnt + 1.
  - When the COUNT-th beat is accepted (cnt==COUNT-1), go to HOLD.
- HOLD state:
  - in_ready=0, out_valid=1.
  - out_sum=acc and out_hi=hi stay stable while out_valid&&!out_ready.
  - On out_ready: acc, hi and cnt are zeroed and the state goes to ACC.
- Arithmetic: the total is {out_hi, out_sum}, exact because COUNT·(2^WIDTH−1) < 2^(WIDTH+HW).
- cnt wraps from COUNT-1 to 0 only via the HOLD transition. It never exceeds COUNT-1.
- clear and rst priority:
  - They have priority over every handshake, including a beat or output acceptance in the same cycle.
  - Either one forces ACC with acc=0, hi=0, cnt=0; an in-flight beat is dropped.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_hi=0, out_ovf=0.

## Timing
- Operand acceptance: in_ready depends only on state, not combinationally on in_valid.
- Back-to-back beats are accepted every cycle while in ACC.
- Output latency: out_valid rises the cycle after the COUNT-th accepted beat.
- Throughput: at best one frame every COUNT+1 cycles, when out_ready is held high.
- Output handoff:
  - The output is accepted in the first HOLD cycle if out_ready=1.
  - in_ready returns on the next cycle.
  - No operand is accepted in a HOLD cycle, even when out_ready=1.
- Adder path: combinational from the acc and in_data registers to acc. No internal pipelining.

## Configuration
- ACC_SAT_EN, undefined:
  - Wrap-and-count behaviour as above.
  - out_ovf is absent.
- ACC_SAT_EN, defined:
  - Each carry sets a sticky ovf flag.
  - While ovf=1, acc is forced to all-ones and hi is held at 0.
  - out_ovf=ovf.
  - ovf clears on output acceptance, clear or rst.

## Structure
- Package acc_pkg holds:
  - the state enum {ACC, HOLD};
  - a clog2-based helper used for HW;
  - a localparam for the default WIDTH and COUNT.
- One sub-module: the existing `carryadder`, instantiated once with size=WIDTH. The block does not re-implement the adder.

## Test plan
All scenarios use WIDTH=4, COUNT=4.
- Reset release:
  - Stimulus: apply rst for 2 cycles, then release.
  - Required response: in_ready=1, out_valid=0, out_sum=0, out_hi=0.
- Nominal frame:
  - Stimulus: beats 3,5,7,9 on consecutive cycles.
  - Required response: out_valid on the next cycle, out_sum=8, out_hi=1. With ACC_SAT_EN: out_sum=15, out_ovf=1.
- Maximum operands:
  - Stimulus: beats 15,15,15,15.
  - Required response: out_sum=12, out_hi=3, which checks the exact carry count.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in HOLD while in_valid=1.
  - Required response: outputs stable, in_ready=0, no beat consumed. After out_ready=1 for one cycle, in_ready=1 on the next cycle.
- Clear mid-frame:
  - Stimulus: beats 4,4, then clear asserted together with a third beat, then beats 1,2,3,4.
  - Required response: the third beat is dropped; the total is out_sum=10, out_hi=0.
- Simultaneous rst and out_ready in HOLD:
  - Stimulus: assert rst and out_ready in the same HOLD cycle.
  - Required response: the block returns to reset values; no second out_valid pulse.
